// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch with a 1-cycle-latency memory, FQ_DEPTH-entry fetch queue and redirect flush.
// Optional macro IFU_ALIGN_CHECK_EN adds instr_fault and halts fetch at the first misaligned PC.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              AW       = 32,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter int              PC_STEP  = 4,
  parameter int              FQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req,
  output logic [AW-1:0]               imem_addr,
  input  logic [XLEN-1:0]             imem_rdata,
  input  logic                        redirect_valid,
  input  logic [AW-1:0]               redirect_pc,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [XLEN-1:0]             instr_data,
  output logic [AW-1:0]               instr_pc,
  output logic [$clog2(FQ_DEPTH):0]   fq_count
`ifdef IFU_ALIGN_CHECK_EN
  ,
  output logic                        instr_fault
`endif
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  // Downstream handshake: a transfer happens on a rising edge where
  // instr_valid && instr_ready; data/pc hold steady while valid && !ready.

  logic [AW-1:0]   pc;
  logic            inflight;
  logic [AW-1:0]   inflight_pc;
  logic [XLEN-1:0] q_data [FQ_DEPTH];
  logic [AW-1:0]   q_pc   [FQ_DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;

  logic            issue_slot;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] push_data;

`ifdef IFU_ALIGN_CHECK_EN
  logic            q_fault [FQ_DEPTH];
  logic            inflight_fault;
  logic            halted;
  logic            misaligned;
`endif

  always_comb begin
    // The in-flight request already owns a slot, so the queue can never overflow.
    issue_slot = !rst && !redirect_valid && ((count + CW'(inflight)) < CW'(FQ_DEPTH));
`ifdef IFU_ALIGN_CHECK_EN
    misaligned = (pc % AW'(PC_STEP)) != '0;
    issue_slot = issue_slot && !halted;
    imem_req   = issue_slot && !misaligned;
    push_data  = inflight_fault ? '0 : imem_rdata;
`else
    imem_req   = issue_slot;
    push_data  = imem_rdata;
`endif
    imem_addr   = pc;
    push        = inflight && !redirect_valid;
    instr_valid = (count != '0);
    pop         = instr_valid && instr_ready;
    instr_data  = instr_valid ? q_data[head] : '0;
    instr_pc    = instr_valid ? q_pc[head]   : '0;
    fq_count    = count;
`ifdef IFU_ALIGN_CHECK_EN
    instr_fault = instr_valid ? q_fault[head] : 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
`ifdef IFU_ALIGN_CHECK_EN
      inflight_fault <= 1'b0;
      halted         <= 1'b0;
`endif
    end else begin
      inflight    <= issue_slot;
      inflight_pc <= pc;
      if (imem_req) pc <= pc + AW'(PC_STEP);
`ifdef IFU_ALIGN_CHECK_EN
      inflight_fault <= misaligned;
      if (issue_slot && misaligned) halted <= 1'b1;
`endif
      if (redirect_valid) begin
        // A pop in this cycle is still a real transfer; the flush just drops the rest.
        pc    <= redirect_pc;
        head  <= '0;
        tail  <= '0;
        count <= '0;
`ifdef IFU_ALIGN_CHECK_EN
        halted <= 1'b0;
`endif
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_data[tail] <= push_data;
      q_pc[tail]   <= inflight_pc;
`ifdef IFU_ALIGN_CHECK_EN
      q_fault[tail] <= inflight_fault;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: expected {pc,data} pushed by the script, popped by a handshake monitor.
// A second instance with RESET_PC=0xFFFF_FFF8 checks address wrap.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, w_imem_req;
  logic [31:0] imem_addr, w_imem_addr;
  logic [31:0] imem_rdata, w_imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, w_instr_valid;
  logic        instr_ready;
  logic        w_instr_ready;
  logic [31:0] instr_data, w_instr_data;
  logic [31:0] instr_pc, w_instr_pc;
  logic [2:0]  fq_count, w_fq_count;
`ifdef IFU_ALIGN_CHECK_EN
  logic        instr_fault, w_instr_fault;
`endif

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [31:0] last_addr = '0;
  logic        saw_200 = 1'b0;
  int          wrap_cnt = 0;
  logic [31:0] wrap_pcs [3];
  logic [31:0] wrap_dat [3];

  // ---------------- clock / reset / DUTs ----------------
  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(32), .AW(32), .RESET_PC(32'h0), .PC_STEP(4), .FQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc), .fq_count(fq_count)
`ifdef IFU_ALIGN_CHECK_EN
    , .instr_fault(instr_fault)
`endif
  );

  instr_fetch_unit #(.XLEN(32), .AW(32), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4), .FQ_DEPTH(4)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .instr_valid(w_instr_valid),
    .instr_ready(w_instr_ready), .instr_data(w_instr_data), .instr_pc(w_instr_pc), .fq_count(w_fq_count)
`ifdef IFU_ALIGN_CHECK_EN
    , .instr_fault(w_instr_fault)
`endif
  );

  assign w_instr_ready = 1'b1;

  // Memory model: word = address ^ 0xA5A5_0000, one cycle after the request.
  always @(posedge clk) begin
    imem_rdata   <= imem_addr ^ 32'hA5A5_0000;
    w_imem_rdata <= w_imem_addr ^ 32'hA5A5_0000;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] pc);
    exp_q.push_back({pc, pc ^ 32'hA5A5_0000});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got pc %0h data %0h expected none", instr_pc, instr_data);
      end else begin
        e = exp_q.pop_front();
        if ({instr_pc, instr_data} !== e) begin
          errors++;
          $display("FAIL output: got pc %0h data %0h expected pc %0h data %0h",
                   instr_pc, instr_data, e[63:32], e[31:0]);
        end
      end
    end
    if (imem_req === 1'b1) begin
      last_addr = imem_addr;
      if (imem_addr == 32'h200) saw_200 = 1'b1;
    end
    if (w_instr_valid === 1'b1 && wrap_cnt < 3) begin
      wrap_pcs[wrap_cnt] = w_instr_pc;
      wrap_dat[wrap_cnt] = w_instr_data;
      wrap_cnt++;
    end
  end

  // ---------------- directed script ----------------
  initial begin
    rst = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    cyc(); cyc();
    neg();
    chk("reset_valid", 64'(instr_valid), 64'd0);
    chk("reset_count", 64'(fq_count), 64'd0);
    chk("reset_req", 64'(imem_req), 64'd0);
    chk("reset_data_pc", {instr_pc, instr_data}, 64'd0);

    // Streaming: cycles 0..7 accepted, pcs 0x0..0x14; then 8 more after backpressure.
    cyc(); rst = 1'b0;
    for (int i = 0; i < 14; i++) exp_push(32'(i * 4));
    neg();
    chk("c0_req", 64'(imem_req), 64'd1);
    chk("c0_addr", 64'(imem_addr), 64'h0);
    cyc(); neg();
    chk("c1_valid", 64'(instr_valid), 64'd0);
    chk("c1_addr", 64'(imem_addr), 64'h4);
    cyc(); neg();
    chk("c2_valid", 64'(instr_valid), 64'd1);
    repeat (6) cyc();
    instr_ready = 1'b0;

    // Backpressure for 20 cycles: saturate at 4 entries 0x18..0x24.
    repeat (19) cyc();
    neg();
    chk("bp_count", 64'(fq_count), 64'd4);
    chk("bp_req", 64'(imem_req), 64'd0);
    chk("bp_head_pc", 64'(instr_pc), 64'h18);
    chk("bp_last_addr", 64'(last_addr), 64'h24);
    cyc(); instr_ready = 1'b1;
    repeat (8) cyc();
    instr_ready = 1'b0;
    repeat (4) cyc();
    neg();
    chk("refill_count", 64'(fq_count), 64'd4);
    chk("stream_drained", 64'(exp_q.size()), 64'd0);

    // Reset for one cycle with a full queue.
    cyc(); rst = 1'b1;
    neg();
    chk("rst_req", 64'(imem_req), 64'd0);
    cyc(); rst = 1'b0;
    neg();
    chk("post_rst_valid", 64'(instr_valid), 64'd0);
    chk("post_rst_count", 64'(fq_count), 64'd0);
    chk("post_rst_addr", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h0});

    // Redirect with 3 queued (0,4,8) and 0xC in flight.
    repeat (4) cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    neg();
    chk("pre_redir_count", 64'(fq_count), 64'd3);
    chk("redir_req", 64'(imem_req), 64'd0);
    cyc(); redirect_valid = 1'b0;
    neg();
    chk("redir_valid_r1", 64'(instr_valid), 64'd0);
    chk("redir_count_r1", 64'(fq_count), 64'd0);
    chk("redir_addr_r1", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h100});
    cyc(); neg();
    chk("redir_valid_r2", 64'(instr_valid), 64'd0);
    cyc(); instr_ready = 1'b1;
    exp_push(32'h100); exp_push(32'h104);
    exp_push(32'h300); exp_push(32'h304); exp_push(32'h308); exp_push(32'h30C);
    neg();
    chk("redir_valid_r3", 64'(instr_valid), 64'd1);
    chk("redir_pc_r3", 64'(instr_pc), 64'h100);

    // Back-to-back redirects: 0x200 then 0x300; 0x104 handshake in the first is honoured.
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h200;
    cyc(); redirect_pc = 32'h300;
    neg();
    chk("b2b_valid", 64'(instr_valid), 64'd0);
    chk("b2b_req", 64'(imem_req), 64'd0);
    cyc(); redirect_valid = 1'b0;
    neg();
    chk("b2b_addr", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h300});
    repeat (6) cyc();
    instr_ready = 1'b0;
    repeat (3) cyc();
    neg();
    chk("redir_drained", 64'(exp_q.size()), 64'd0);
    chk("no_fetch_200", 64'(saw_200), 64'd0);

`ifdef IFU_ALIGN_CHECK_EN
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h102;
    cyc(); redirect_valid = 1'b0;
    neg();
    chk("align_req_r1", 64'(imem_req), 64'd0);
    cyc(); neg();
    chk("align_req_r2", 64'(imem_req), 64'd0);
    chk("align_valid_r2", 64'(instr_valid), 64'd0);
    cyc(); neg();
    chk("align_entry", {instr_pc, instr_data}, {32'h102, 32'h0});
    chk("align_fault", {62'd0, instr_valid, instr_fault}, 64'd3);
    chk("align_count", 64'(fq_count), 64'd1);
    repeat (3) cyc();
    neg();
    chk("align_halted_req", 64'(imem_req), 64'd0);
    chk("align_halted_count", 64'(fq_count), 64'd1);
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h400;
    cyc(); redirect_valid = 1'b0;
    neg();
    chk("align_resume", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h400});
`endif

    // Wrap instance: first three outputs after the initial reset.
    chk("wrap_cnt", 64'(wrap_cnt), 64'd3);
    chk("wrap_pc0", {wrap_pcs[0], wrap_dat[0]}, {32'hFFFF_FFF8, 32'hFFFF_FFF8 ^ 32'hA5A5_0000});
    chk("wrap_pc1", {wrap_pcs[1], wrap_dat[1]}, {32'hFFFF_FFFC, 32'hFFFF_FFFC ^ 32'hA5A5_0000});
    chk("wrap_pc2", {wrap_pcs[2], wrap_dat[2]}, {32'h0000_0000, 32'hA5A5_0000});

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
